// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - BCD stopwatch with lap freeze, terminal hold and registered digit words
module stopwatch_core #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [5:0] I7,
  output logic [5:0] I6,
  output logic [5:0] I5,
  output logic [5:0] I4,
  output logic [5:0] I3,
  output logic [5:0] I2,
  output logic [5:0] I1,
  output logic [5:0] I0,
  output logic       running,
  output logic       overflow
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_LAP,
    ST_PAUSED,
    ST_OVF
  } state_t;

  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  // Per-digit maxima double as the terminal count 99:59:59.99.
  localparam logic [31:0]     TIME_MAX   = 32'h9959_5999;

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] presc;
  logic [31:0]   time_q;
  logic [31:0]   time_inc;
  logic [31:0]   time_d;
  logic [31:0]   snap_q;
  logic [31:0]   disp;
  logic          counting;
  logic          tick;
  logic          at_max;
  logic          carry;
  logic          zero_time;
  logic          take_snap;
  logic          ovf_ind;
  logic          en_h1;
  logic          en_h0;

  function automatic logic [5:0] digit_word(input logic en, input logic [3:0] hex, input logic dp_n);
    return {en, en ? hex : 4'd0, dp_n};
  endfunction

  assign counting = (state == ST_RUN) || (state == ST_LAP);
  assign tick     = counting && (presc == PRESC_LAST);
  assign at_max   = (time_q == TIME_MAX);

  always_comb begin : bcd_increment
    time_inc = time_q;
    carry    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (time_q[4*i +: 4] == TIME_MAX[4*i +: 4]) begin
          time_inc[4*i +: 4] = 4'd0;
        end else begin
          time_inc[4*i +: 4] = time_q[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  // A terminal tick outranks any pulse arriving in the same cycle.
  always_comb begin : next_state
    state_n   = state;
    zero_time = 1'b0;
    take_snap = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_stop) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (tick && at_max) state_n = ST_OVF;
        else if (start_stop) state_n = ST_PAUSED;
        else if (lap) begin
          state_n   = ST_LAP;
          take_snap = 1'b1;
        end
      end
      ST_LAP: begin
        if (tick && at_max) state_n = ST_OVF;
        else if (start_stop) state_n = ST_PAUSED;
        else if (lap) state_n = ST_RUN;
      end
      ST_PAUSED: begin
        if (clear) begin
          state_n   = ST_IDLE;
          zero_time = 1'b1;
        end else if (start_stop) state_n = ST_RUN;
      end
      ST_OVF: begin
        if (clear) begin
          state_n   = ST_IDLE;
          zero_time = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign time_d  = zero_time ? 32'd0 : ((tick && !at_max) ? time_inc : time_q);
  assign disp    = (state == ST_LAP) ? snap_q : time_q;
  assign ovf_ind = (state == ST_OVF);
  assign en_h1   = |disp[31:28];
  assign en_h0   = |disp[31:24];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      presc    <= '0;
      time_q   <= 32'd0;
      snap_q   <= 32'd0;
      running  <= 1'b0;
      overflow <= 1'b0;
      I7       <= 6'b000001;
      I6       <= 6'b000001;
      I5       <= 6'b100001;
      I4       <= 6'b100000;
      I3       <= 6'b100001;
      I2       <= 6'b100000;
      I1       <= 6'b100001;
      I0       <= 6'b100001;
    end else begin
      state  <= state_n;
      time_q <= time_d;
      if (take_snap) snap_q <= time_q;
      if (zero_time) presc <= '0;
      else if (counting) presc <= tick ? '0 : presc + PW'(1);
      running  <= (state_n == ST_RUN) || (state_n == ST_LAP);
      overflow <= (state_n == ST_OVF);
      // dp is active-low; the overflow indication lights every point.
      I7 <= digit_word(en_h1, disp[31:28], ~ovf_ind);
      I6 <= digit_word(en_h0, disp[27:24], ~ovf_ind & ~en_h0);
      I5 <= digit_word(1'b1, disp[23:20], ~ovf_ind);
      I4 <= digit_word(1'b1, disp[19:16], 1'b0);
      I3 <= digit_word(1'b1, disp[15:12], ~ovf_ind);
      I2 <= digit_word(1'b1, disp[11:8], 1'b0);
      I1 <= digit_word(1'b1, disp[7:4], ~ovf_ind);
      I0 <= digit_word(1'b1, disp[3:0], ~ovf_ind);
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - stopwatch_core bench: directed steps plus random pulses against a centisecond model
module tb_stopwatch_core;

  localparam int TD     = 4;
  localparam int MAX_CS = 35999999;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_LAP  = 2;
  localparam int M_PAUS = 3;
  localparam int M_OVF  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [5:0] I7, I6, I5, I4, I3, I2, I1, I0;
  logic       running;
  logic       overflow;
  logic [5:0] dw [8];

  int          checks = 0;
  int          errors = 0;
  int          m_state, m_cs, m_snap, m_pre;
  logic [5:0]  e_word [8];
  logic        e_run, e_ovf;
  logic [31:0] force_val;

  stopwatch_core #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .I7(I7), .I6(I6), .I5(I5), .I4(I4), .I3(I3), .I2(I2), .I1(I1), .I0(I0),
    .running(running), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign dw[0] = I0; assign dw[1] = I1; assign dw[2] = I2; assign dw[3] = I3;
  assign dw[4] = I4; assign dw[5] = I5; assign dw[6] = I6; assign dw[7] = I7;

  function automatic logic [31:0] to_bcd(input int cs);
    int h, m, s, c;
    h = cs / 360000; m = (cs / 6000) % 60; s = (cs / 100) % 60; c = cs % 100;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [5:0] exp_word(input int idx, input int d, input bit ovf);
    int h, m, s, c;
    int dig [8];
    bit en, lit;
    h = d / 360000; m = (d / 6000) % 60; s = (d / 100) % 60; c = d % 100;
    dig[7] = h / 10; dig[6] = h % 10; dig[5] = m / 10; dig[4] = m % 10;
    dig[3] = s / 10; dig[2] = s % 10; dig[1] = c / 10; dig[0] = c % 10;
    en  = 1'b1;
    lit = (idx == 6) || (idx == 4) || (idx == 2);
    if (idx == 7) en = (dig[7] != 0);
    if (idx == 6) en = (h != 0);
    if (!en) lit = 1'b0;
    if (ovf) lit = 1'b1;
    return {en, en ? 4'(dig[idx]) : 4'd0, ~lit};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_cs = 0; m_snap = 0; m_pre = 0;
    for (int i = 0; i < 8; i++) e_word[i] = exp_word(i, 0, 1'b0);
    e_run = 1'b0; e_ovf = 1'b0;
  endtask

  task automatic model_step(input bit ss, input bit lp, input bit cl);
    int  d, cs_old;
    bit  cnt, tk, hit_max;
    d = (m_state == M_LAP) ? m_snap : m_cs;
    for (int i = 0; i < 8; i++) e_word[i] = exp_word(i, d, m_state == M_OVF);
    cs_old  = m_cs;
    cnt     = (m_state == M_RUN) || (m_state == M_LAP);
    tk      = cnt && (m_pre == TD - 1);
    hit_max = 1'b0;
    if (cnt) m_pre = tk ? 0 : m_pre + 1;
    if (tk) begin
      if (m_cs == MAX_CS) hit_max = 1'b1;
      else m_cs = m_cs + 1;
    end
    case (m_state)
      M_IDLE: if (ss) m_state = M_RUN;
      M_RUN: begin
        if (hit_max) m_state = M_OVF;
        else if (ss) m_state = M_PAUS;
        else if (lp) begin m_state = M_LAP; m_snap = cs_old; end
      end
      M_LAP: begin
        if (hit_max) m_state = M_OVF;
        else if (ss) m_state = M_PAUS;
        else if (lp) m_state = M_RUN;
      end
      M_PAUS: begin
        if (cl) begin m_state = M_IDLE; m_cs = 0; m_pre = 0; end
        else if (ss) m_state = M_RUN;
      end
      default: if (cl) begin m_state = M_IDLE; m_cs = 0; m_pre = 0; end
    endcase
    e_run = (m_state == M_RUN) || (m_state == M_LAP);
    e_ovf = (m_state == M_OVF);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s I%0d", tag, i), 32'(dw[i]), 32'(e_word[i]));
    chk({tag, " running"}, 32'(running), 32'(e_run));
    chk({tag, " overflow"}, 32'(overflow), 32'(e_ovf));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " I7"}, 32'(I7), 32'(6'b000001));
    chk({tag, " I6"}, 32'(I6), 32'(6'b000001));
    chk({tag, " I5"}, 32'(I5), 32'(6'b100001));
    chk({tag, " I4"}, 32'(I4), 32'(6'b100000));
    chk({tag, " I3"}, 32'(I3), 32'(6'b100001));
    chk({tag, " I2"}, 32'(I2), 32'(6'b100000));
    chk({tag, " I1"}, 32'(I1), 32'(6'b100001));
    chk({tag, " I0"}, 32'(I0), 32'(6'b100001));
    chk({tag, " running"}, 32'(running), 32'd0);
    chk({tag, " overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic cycle(input bit ss, input bit lp, input bit cl);
    start_stop = ss; lap = lp; clear = cl;
    @(posedge clk);
    model_step(ss, lp, cl);
    @(negedge clk);
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    compare_all("model");
  endtask

  task automatic run(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Only used while the time is held (IDLE, PAUSED or OVF).
  task automatic preload(input int cs);
    force_val = to_bcd(cs);
    force dut.time_q = force_val;
    @(posedge clk);
    m_cs = cs;
    model_step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    release dut.time_q;
    compare_all("preload");
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    reset = 1'b0;
    model_reset();

    // first tick and 1 s
    cycle(1, 0, 0); run(5);
    chk("first_tick I0", 32'(I0), 32'(6'b100011));
    chk("first_tick running", 32'(running), 32'd1);
    run(396);
    chk("one_sec I2", 32'(I2), 32'(6'b100010));
    chk("one_sec I1", 32'(I1), 32'(6'b100001));
    chk("one_sec I0", 32'(I0), 32'(6'b100001));

    // clear ignored in RUN, pause holds, clear from PAUSED
    cycle(0, 0, 1); run(2);
    cycle(1, 0, 0); run(8);
    cycle(0, 0, 1); run(1);
    chk_reset("clear_paused");

    // minute carry, then hour carry unblanks I6
    preload(5999);
    cycle(1, 0, 0); run(5);
    chk("min_carry I7", 32'(I7), 32'(6'b000001));
    chk("min_carry I6", 32'(I6), 32'(6'b000001));
    chk("min_carry I4", 32'(I4), 32'(6'b100010));
    chk("min_carry I3", 32'(I3), 32'(6'b100001));
    chk("min_carry I2", 32'(I2), 32'(6'b100000));
    chk("min_carry I0", 32'(I0), 32'(6'b100001));
    cycle(1, 0, 0);
    preload(359999);
    cycle(1, 0, 0); run(5);
    chk("hour_carry I7", 32'(I7), 32'(6'b000001));
    chk("hour_carry I6", 32'(I6), 32'(6'b100010));
    chk("hour_carry I5", 32'(I5), 32'(6'b100001));
    chk("hour_carry I4", 32'(I4), 32'(6'b100000));

    // lap freeze at 1.23, release at 1.73
    cycle(1, 0, 0); cycle(0, 0, 1);
    cycle(1, 0, 0); run(492);
    cycle(0, 1, 0); run(199);
    chk("lap_hold running", 32'(running), 32'd1);
    chk("lap_hold I2", 32'(I2), 32'(6'b100010));
    chk("lap_hold I1", 32'(I1), 32'(6'b100101));
    chk("lap_hold I0", 32'(I0), 32'(6'b100111));
    cycle(0, 1, 0); run(1);
    chk("lap_live I2", 32'(I2), 32'(6'b100010));
    chk("lap_live I1", 32'(I1), 32'(6'b101111));
    chk("lap_live I0", 32'(I0), 32'(6'b100111));

    // terminal count
    cycle(1, 0, 0);
    preload(MAX_CS);
    cycle(1, 0, 0); run(5);
    chk("ovf overflow", 32'(overflow), 32'd1);
    chk("ovf running", 32'(running), 32'd0);
    chk("ovf I7", 32'(I7), 32'(6'b110010));
    chk("ovf I6", 32'(I6), 32'(6'b110010));
    chk("ovf I5", 32'(I5), 32'(6'b101010));
    chk("ovf I3", 32'(I3), 32'(6'b101010));
    chk("ovf I0", 32'(I0), 32'(6'b110010));
    cycle(1, 0, 0); cycle(0, 1, 0); run(3);
    chk("ovf_ignore overflow", 32'(overflow), 32'd1);
    chk("ovf_ignore I0", 32'(I0), 32'(6'b110010));
    cycle(0, 0, 1); run(1);
    chk_reset("ovf_clear");

    // clear beats start_stop in PAUSED
    cycle(1, 0, 0); run(30);
    cycle(1, 0, 0); run(3);
    cycle(1, 0, 1); run(1);
    chk_reset("clear_prio");

    // asynchronous reset mid-count
    cycle(1, 0, 0); run(10);
    #2 reset = 1'b1;
    #1 chk_reset("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    run(6);
    cycle(1, 0, 0); run(6);

    // random pulses
    for (int r = 0; r < 6; r++) begin
      if (m_state == M_IDLE || m_state == M_PAUS) begin
        case (r % 4)
          0: preload(MAX_CS - 40);
          1: preload(359990);
          2: preload(5990);
          default: preload(0);
        endcase
      end
      for (int k = 0; k < 500; k++) begin
        bit ss, lp, cl;
        ss = ($urandom_range(0, 11) == 0);
        lp = ($urandom_range(0, 11) == 0);
        cl = ($urandom_range(0, 23) == 0);
        cycle(ss, lp, cl);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter TICK_DIV, default 1_000_000, is the number of clk cycles per 1/100 s (100 MHz clock); legal range 2 and above.
REQ-002 Port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 Port start_stop, input, 1 bit, single-cycle pulse (already debounced) that toggles between run and stop.
REQ-005 Port lap, input, 1 bit, single-cycle pulse that toggles the lap freeze of the display.
REQ-006 Port clear, input, 1 bit, single-cycle pulse that zeroes the time.
REQ-007 Ports I7..I0, output, 6 bits each, digit words for the display driver; I7 is the leftmost digit; format {enable[5], hex[4:1], dp[0]}.
REQ-008 Port running, output, 1 bit, high in RUN and LAP.
REQ-009 Port overflow, output, 1 bit, high in OVF.

Function
REQ-010 Time counters are BCD, in the order hours-tens, hours-units, minutes-tens, minutes-units, seconds-tens, seconds-units, centi-tens, centi-units.
- Ranges: hours 00-99, minutes 00-59, seconds 00-59, centiseconds 00-99.
- Map: I7=H1, I6=H0, I5=M1, I4=M0, I3=S1, I2=S0, I1=C1, I0=C0.
REQ-011 A prescaler counts 0..TICK_DIV-1 only while the state is RUN or LAP.
- It emits a one-cycle tick when it wraps.
- It holds its value in PAUSED and is cleared by clear and by reset.
REQ-012 On each tick the time increments by 0.01 s with full BCD ripple carry in the same cycle.
- Example: 00:59:59.99 -> 01:00:00.00.
REQ-013 FSM states are IDLE, RUN, LAP, PAUSED and OVF; at most one transition per cycle.
REQ-014 IDLE: start_stop -> RUN; lap and clear are ignored.
REQ-015 RUN:
- start_stop -> PAUSED.
- lap -> LAP; the current time is copied into the display snapshot.
- clear is ignored.
REQ-016 LAP:
- Counting continues while the display shows the snapshot.
- lap -> RUN, and the display tracks live time again.
- start_stop -> PAUSED, with the display returning to live time.
- clear is ignored.
REQ-017 PAUSED:
- start_stop -> RUN, resuming from the held time and prescaler value.
- clear -> IDLE, with time and prescaler zeroed.
- lap is ignored.
REQ-018 Terminal count: a tick at 99:59:59.99 leaves the time at 99:59:59.99 and enters OVF; the time never wraps.
REQ-019 OVF: clear -> IDLE with time zeroed; start_stop and lap are ignored.
REQ-020 Simultaneous pulses in one cycle have priority clear > start_stop > lap; lower-priority pulses in that cycle are discarded.
REQ-021 I7..I0 are registered, so the digit words reflect counter/snapshot state with one cycle of latency after the change.
REQ-022 Enable bit:
- The enable bit is 1 for every digit, except I7 and I6.
- I7 and I6 have enable=0 when the displayed hours value is 00 (leading-zero blanking).
- I7 alone has enable=0 when H1=0.
REQ-023 The dp bit is active-low (0 = lit).
- dp=0 on I6, I4 and I2; dp=1 elsewhere.
- I6 has dp=1 when I6 is blanked.
REQ-024 Hex field: a blanked digit drives hex=0.
REQ-025 In OVF, bit 0 of every digit is 0 (all decimal points lit) as the overflow indication.

Reset
REQ-026 Asserting reset immediately forces the following values, independent of clk:
- State IDLE; time, snapshot and prescaler are 0.
- running=0, overflow=0.
- I7=I6=6'b000001.
- I5=6'b100001, I4=6'b100000, I3=6'b100001, I2=6'b100000, I1=6'b100001, I0=6'b100001.
REQ-027 Reset asserted mid-count has the same effect as REQ-026; the first tick after release requires a fresh start_stop followed by TICK_DIV cycles.

Verification (bench uses TICK_DIV=4)
REQ-028 Release reset, pulse start_stop, run 4 cycles -> I0 hex=1, running=1; after 100 ticks -> S0=1, C1=C0=0.
REQ-029 Preload by running to 00:00:59.99, then one tick -> M0=1, S1=S0=C1=C0=0, I6/I7 still blanked; at 01:00:00.00 -> I6 enable=1, hex=1, dp=0.
REQ-030 In RUN, pulse lap at 00:00:01.23 -> digits hold 1.23 for 50 ticks while running=1; second lap -> display shows live 00:00:01.73.
REQ-031 In RUN, pulse clear -> no change; start_stop -> PAUSED, held 8 cycles with no change; clear -> all time digits 0, state IDLE.
REQ-032 Force time to 99:59:59.99 -> next tick leaves 99:59:59.99, overflow=1, all dp bits 0; start_stop ignored; clear -> IDLE with overflow=0.
REQ-033 In PAUSED, assert clear and start_stop in the same cycle -> IDLE with time zeroed, running=0.
